// File: rtl/host_rd_if.sv
// Command, read-descriptor submission, completion and done handshakes of the host read requester.
interface host_rd_if #(
  parameter int VADDR_BITS = 48,
  parameter int LEN_BITS   = 28
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [VADDR_BITS-1:0] cmd_vaddr;
  logic [LEN_BITS-1:0]   cmd_len;

  logic                  sq_rd_valid;
  logic                  sq_rd_ready;
  logic [VADDR_BITS-1:0] sq_rd_vaddr;
  logic [LEN_BITS-1:0]   sq_rd_len;
  logic                  sq_rd_last;

  logic                  cq_rd_valid;

  logic                  done_valid;
  logic                  done_ready;
  logic [LEN_BITS-1:0]   done_bytes;

  modport master (
    input  cmd_valid, cmd_vaddr, cmd_len,
    output cmd_ready,
    output sq_rd_valid, sq_rd_vaddr, sq_rd_len, sq_rd_last,
    input  sq_rd_ready,
    input  cq_rd_valid,
    output done_valid, done_bytes,
    input  done_ready
  );

  modport slave (
    output cmd_valid, cmd_vaddr, cmd_len,
    input  cmd_ready,
    input  sq_rd_valid, sq_rd_vaddr, sq_rd_len, sq_rd_last,
    output sq_rd_ready,
    output cq_rd_valid,
    input  done_valid, done_bytes,
    output done_ready
  );
endinterface

// File: rtl/host_rd_requester.sv
// Splits one host read command into CHUNK_BYTES-bounded sq_rd descriptors under a credit limit.
// Optional HOST_RD_STATS_EN adds stat_cmds / stat_descs wrapping counters.
module host_rd_requester #(
  parameter int VADDR_BITS      = 48,
  parameter int LEN_BITS        = 28,
  parameter int CHUNK_BYTES     = 4096,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic       aclk,
  input  logic       areset,
  host_rd_if.master  bus,
  output logic       busy,
  output logic       err_spurious
`ifdef HOST_RD_STATS_EN
  ,
  output logic [31:0] stat_cmds,
  output logic [31:0] stat_descs
`endif
);

  localparam int OFF_W = $clog2(CHUNK_BYTES);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]    MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [LEN_BITS-1:0] CHUNK_LEN = LEN_BITS'(CHUNK_BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]      out_cnt, out_n;
  logic                  cmd_ready_q, sq_valid_q, sq_last_q, done_valid_q, busy_q, err_q;
  logic [VADDR_BITS-1:0] sq_vaddr_q;
  logic [LEN_BITS-1:0]   sq_len_q, done_bytes_q, rem_q;

  logic                  cmd_hs, sq_hs, done_hs, cq_ok, cq_spur;
  logic                  load_desc;
  logic [VADDR_BITS-1:0] nxt_addr;
  logic [LEN_BITS-1:0]   nxt_rem, desc_len;

  // Bytes up to the next chunk boundary, capped by what is left of the command.
  function automatic logic [LEN_BITS-1:0] chunk_len(input logic [OFF_W-1:0] off,
                                                    input logic [LEN_BITS-1:0] rem);
    logic [LEN_BITS-1:0] room;
    room = CHUNK_LEN - LEN_BITS'(off);
    return (rem < room) ? rem : room;
  endfunction

  assign cmd_hs  = cmd_ready_q & bus.cmd_valid;
  assign sq_hs   = sq_valid_q & bus.sq_rd_ready;
  assign done_hs = done_valid_q & bus.done_ready;
  assign cq_ok   = bus.cq_rd_valid & (out_cnt != '0);
  assign cq_spur = bus.cq_rd_valid & (out_cnt == '0);

  always_comb begin
    out_n = out_cnt;
    case ({sq_hs, cq_ok})
      2'b10:   out_n = out_cnt + CNT_W'(1);
      2'b01:   out_n = out_cnt - CNT_W'(1);
      default: out_n = out_cnt;
    endcase
  end

  always_comb begin
    state_n   = state;
    load_desc = 1'b0;
    nxt_addr  = sq_vaddr_q;
    nxt_rem   = rem_q;
    case (state)
      IDLE: begin
        if (cmd_hs) begin
          nxt_addr = bus.cmd_vaddr;
          nxt_rem  = bus.cmd_len;
          if (bus.cmd_len == '0) begin
            state_n = DONE;
          end else begin
            state_n   = ISSUE;
            load_desc = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (sq_hs) begin
          nxt_addr = sq_vaddr_q + VADDR_BITS'(sq_len_q);
          nxt_rem  = rem_q - sq_len_q;
          if (sq_last_q) state_n = DRAIN;
          else           load_desc = 1'b1;
        end
      end
      DRAIN: begin
        if (out_n == '0) state_n = DONE;
      end
      DONE: begin
        if (done_hs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    desc_len = chunk_len(nxt_addr[OFF_W-1:0], nxt_rem);
  end

  // Control and registered outputs; all outputs derive from next-state so they are registered.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= IDLE;
      out_cnt      <= '0;
      err_q        <= 1'b0;
      cmd_ready_q  <= 1'b1;
      sq_valid_q   <= 1'b0;
      sq_vaddr_q   <= '0;
      sq_len_q     <= '0;
      sq_last_q    <= 1'b0;
      done_valid_q <= 1'b0;
      done_bytes_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state        <= state_n;
      out_cnt      <= out_n;
      err_q        <= err_q | cq_spur;
      cmd_ready_q  <= (state_n == IDLE);
      sq_valid_q   <= (state_n == ISSUE) && (out_n < MAX_CNT);
      done_valid_q <= (state_n == DONE);
      busy_q       <= (state_n != IDLE);
      if (cmd_hs) done_bytes_q <= bus.cmd_len;
      if (load_desc) begin
        sq_vaddr_q <= nxt_addr;
        sq_len_q   <= desc_len;
        sq_last_q  <= (desc_len == nxt_rem);
      end
    end
  end

  // Remaining byte count is pure data; it is always loaded before ISSUE reads it.
  always_ff @(posedge aclk) begin
    rem_q <= nxt_rem;
  end

`ifdef HOST_RD_STATS_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      stat_cmds  <= '0;
      stat_descs <= '0;
    end else begin
      if (done_hs) stat_cmds  <= stat_cmds + 32'd1;
      if (sq_hs)   stat_descs <= stat_descs + 32'd1;
    end
  end
`endif

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.sq_rd_valid = sq_valid_q;
  assign bus.sq_rd_vaddr = sq_vaddr_q;
  assign bus.sq_rd_len   = sq_len_q;
  assign bus.sq_rd_last  = sq_last_q;
  assign bus.done_valid  = done_valid_q;
  assign bus.done_bytes  = done_bytes_q;
  assign busy            = busy_q;
  assign err_spurious    = err_q;

endmodule

// File: tb/tb_host_rd_requester.sv
// Directed bench for host_rd_requester: scoreboard queues filled by stimulus, popped by a monitor.
module tb_host_rd_requester;

  logic aclk = 1'b0;
  logic areset;
  logic busy, err_spurious;
  logic auto_en, auto_cq, man_cq;
  logic [4:0] dl;

`ifdef HOST_RD_STATS_EN
  logic [31:0] stat_cmds, stat_descs;
`endif

  host_rd_if #(.VADDR_BITS(48), .LEN_BITS(28)) h ();

  host_rd_requester dut (
    .aclk         (aclk),
    .areset       (areset),
    .bus          (h),
    .busy         (busy),
    .err_spurious (err_spurious)
`ifdef HOST_RD_STATS_EN
    ,
    .stat_cmds    (stat_cmds),
    .stat_descs   (stat_descs)
`endif
  );

  always #5 aclk = ~aclk;

  assign h.cq_rd_valid = auto_cq | man_cq;

  typedef struct {
    logic [47:0] a;
    logic [27:0] l;
    logic        last;
  } desc_t;

  desc_t       exp_desc[$];
  logic [27:0] exp_done[$];
  int tests = 0;
  int fails = 0;
  int n_desc = 0;
  int n_done = 0;

  logic        prev_v, prev_r, prev_last, prev_rst;
  logic [47:0] prev_addr;
  logic [27:0] prev_len;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_desc(input logic [47:0] a, input logic [27:0] l, input logic last);
    desc_t d;
    d.a = a; d.l = l; d.last = last;
    exp_desc.push_back(d);
  endtask

  // Monitor: samples on the falling edge, i.e. the values the next rising edge will act on.
  always @(negedge aclk) begin
    desc_t d;
    logic [27:0] eb;
    if (!areset && !prev_rst && prev_v && !prev_r) begin
      check("stall_hold_valid", h.sq_rd_valid, 1'b1);
      check("stall_hold_addr", h.sq_rd_vaddr, prev_addr);
      check("stall_hold_len", h.sq_rd_len, prev_len);
      check("stall_hold_last", h.sq_rd_last, prev_last);
    end
    if (!areset && h.sq_rd_valid && h.sq_rd_ready) begin
      n_desc++;
      if (exp_desc.size() == 0) begin
        tests++; fails++;
        $display("FAIL desc_unexpected: got addr 0x%0h len 0x%0h, required none", h.sq_rd_vaddr, h.sq_rd_len);
      end else begin
        d = exp_desc.pop_front();
        check("desc_addr", h.sq_rd_vaddr, d.a);
        check("desc_len", h.sq_rd_len, d.l);
        check("desc_last", h.sq_rd_last, d.last);
      end
    end
    if (!areset && h.done_valid && h.done_ready) begin
      n_done++;
      if (exp_done.size() == 0) begin
        tests++; fails++;
        $display("FAIL done_unexpected: got bytes 0x%0h, required none", h.done_bytes);
      end else begin
        eb = exp_done.pop_front();
        check("done_bytes", h.done_bytes, eb);
      end
    end
    dl        <= {dl[3:0], h.sq_rd_valid & h.sq_rd_ready & auto_en & ~areset};
    auto_cq   <= dl[4] & auto_en;
    prev_v    <= h.sq_rd_valid;
    prev_r    <= h.sq_rd_ready;
    prev_addr <= h.sq_rd_vaddr;
    prev_len  <= h.sq_rd_len;
    prev_last <= h.sq_rd_last;
    prev_rst  <= areset;
  end

  task automatic check_reset(input string tag);
    check({tag, "_cmd_ready"}, h.cmd_ready, 1'b1);
    check({tag, "_sq_valid"}, h.sq_rd_valid, 1'b0);
    check({tag, "_sq_vaddr"}, h.sq_rd_vaddr, 48'h0);
    check({tag, "_sq_len"}, h.sq_rd_len, 28'h0);
    check({tag, "_sq_last"}, h.sq_rd_last, 1'b0);
    check({tag, "_done_valid"}, h.done_valid, 1'b0);
    check({tag, "_done_bytes"}, h.done_bytes, 28'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err"}, err_spurious, 1'b0);
  endtask

  task automatic send_cmd(input logic [47:0] a, input logic [27:0] l);
    int guard = 0;
    @(posedge aclk); #1;
    while (!h.cmd_ready && guard < 1000) begin
      @(posedge aclk); #1;
      guard++;
    end
    if (!h.cmd_ready) begin
      tests++; fails++;
      $display("FAIL cmd_ready_timeout: got 0, required 1");
    end
    h.cmd_vaddr = a;
    h.cmd_len   = l;
    h.cmd_valid = 1'b1;
    @(posedge aclk); #1;
    h.cmd_valid = 1'b0;
    check("first_desc_valid", h.sq_rd_valid, (l != 0));
    check("zero_len_done_next", h.done_valid, (l == 0));
  endtask

  task automatic wait_done(input int target, input bit rnd, input string name);
    int guard = 0;
    while (n_done < target && guard < 3000) begin
      @(posedge aclk); #1;
      if (rnd) h.sq_rd_ready = 1'($urandom_range(0, 1));
      guard++;
    end
    if (n_done < target) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got %0d commands done, required %0d", name, n_done, target);
    end
    h.sq_rd_ready = 1'b1;
  endtask

  task automatic pulse_cq();
    @(posedge aclk); #1;
    man_cq = 1'b1;
    @(posedge aclk); #1;
    man_cq = 1'b0;
  endtask

  initial begin
    int d0;
    areset = 1'b1;
    auto_en = 1'b0;
    man_cq = 1'b0;
    h.cmd_valid = 1'b0;
    h.cmd_vaddr = '0;
    h.cmd_len = '0;
    h.sq_rd_ready = 1'b1;
    h.done_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    check_reset("reset");

    // Aligned two-chunk command with delayed completions.
    auto_en = 1'b1;
    push_desc(48'h1000, 28'd4096, 1'b0);
    push_desc(48'h2000, 28'd4096, 1'b1);
    exp_done.push_back(28'd8192);
    send_cmd(48'h1000, 28'd8192);
    wait_done(1, 1'b0, "aligned");

    // Unaligned start crossing one boundary.
    push_desc(48'h0F00, 28'h100, 1'b0);
    push_desc(48'h1000, 28'h200, 1'b1);
    exp_done.push_back(28'h300);
    send_cmd(48'h0F00, 28'h300);
    wait_done(2, 1'b0, "unaligned");

    // Zero length: no descriptors.
    d0 = n_desc;
    exp_done.push_back(28'h0);
    send_cmd(48'h7000, 28'h0);
    wait_done(3, 1'b0, "zero_len");
    check("zero_len_no_desc", n_desc - d0, 0);

    // Spurious completion while idle.
    auto_en = 1'b0;
    pulse_cq();
    check("spurious_idle_err", err_spurious, 1'b1);
    check("spurious_idle_busy", busy, 1'b0);

    // Credit stall: 10 chunks, only 8 may be in flight.
    for (int i = 0; i < 10; i++)
      push_desc(48'h10000 + 48'(i) * 48'h1000, 28'd4096, (i == 9));
    exp_done.push_back(28'd40960);
    d0 = n_desc;
    send_cmd(48'h10000, 28'd40960);
    repeat (20) @(posedge aclk);
    #1;
    check("stall_count", n_desc - d0, 8);
    check("stall_valid_low", h.sq_rd_valid, 1'b0);
    man_cq = 1'b1;
    @(posedge aclk); #1;
    check("credit_release_valid", h.sq_rd_valid, 1'b1);
    @(posedge aclk); #1;
    man_cq = 1'b0;
    check("cq_and_hs_same_cycle_valid", h.sq_rd_valid, 1'b1);
    @(posedge aclk); #1;
    check("stall_total_descs", n_desc - d0, 10);
    check("drain_valid_low", h.sq_rd_valid, 1'b0);
    man_cq = 1'b1;
    repeat (8) @(posedge aclk);
    #1 man_cq = 1'b0;
    wait_done(4, 1'b0, "credit");

    // Random backpressure on the descriptor channel.
    auto_en = 1'b1;
    push_desc(48'h30F80, 28'h80, 1'b0);
    push_desc(48'h31000, 28'h1000, 1'b0);
    push_desc(48'h32000, 28'h1000, 1'b0);
    push_desc(48'h33000, 28'h80, 1'b1);
    exp_done.push_back(28'h2100);
    send_cmd(48'h30F80, 28'h2100);
    wait_done(5, 1'b1, "backpressure");

    // Reset in the middle of ISSUE, then a stale completion.
    auto_en = 1'b0;
    h.sq_rd_ready = 1'b0;
    send_cmd(48'h5000, 28'd40960);
    repeat (3) @(posedge aclk);
    #1;
    check("pre_reset_valid", h.sq_rd_valid, 1'b1);
    check("pre_reset_busy", busy, 1'b1);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    check_reset("mid_reset");
    h.sq_rd_ready = 1'b1;
    pulse_cq();
    check("spurious_after_reset", err_spurious, 1'b1);

    repeat (3) @(posedge aclk);
    #1;
    check("leftover_desc", exp_desc.size(), 0);
    check("leftover_done", exp_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    dl = '0;
    auto_cq = 1'b0;
    prev_v = 1'b0;
    prev_r = 1'b0;
    prev_rst = 1'b1;
    prev_addr = '0;
    prev_len = '0;
    prev_last = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
